// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: FSM state encodings, parity modes and the default bit period.
// The receiver imports this package as well.
package rs232_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_POP_REQ  = 3'd1;
  localparam logic [2:0] ST_POP_WAIT = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_DATA     = 3'd4;
  localparam logic [2:0] ST_PARITY   = 3'd5;
  localparam logic [2:0] ST_STOP     = 3'd6;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Data arrives zero-extended to 9 bits, so the padding does not disturb the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    if (mode == PARITY_ODD) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

endpackage

// File: rtl/rs232_tx_unloader_if.sv
// Fifo read handshake between the byte fifo and the RS232 transmit engine.
interface rs232_tx_unloader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (input fifo_empty, input fifo_data, output fifo_pop);
  modport slave  (output fifo_empty, output fifo_data, input fifo_pop);
endinterface

// File: rtl/rs232_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and ticks on the last cycle of every bit.
module rs232_baud_counter
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    if (restart || (cnt_q == LAST_CNT)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = !restart && (cnt_q == LAST_CNT);

endmodule

// File: rtl/rs232_tx_unloader.sv
// RS232 transmit engine: pops one word from the byte fifo and serialises it on tx.
// Outputs are registered decodes of the current state, so they trail the state by one cycle.
module rs232_tx_unloader
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int POP_LATENCY  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  rs232_tx_unloader_if.master        fifo,
  output logic                       tx,
  output logic                       busy,
  output logic                       frame_done,
  output logic [15:0]                bytes_sent
);

  localparam logic [3:0]  LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [15:0] WAIT_INIT = 16'(POP_LATENCY - 1);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [15:0]           wait_q, wait_d;
  logic                  tx_q, tx_d;
  logic                  pop_q, pop_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           bytes_q, bytes_d;
  logic                  bit_tick_s;
  logic                  restart_s;
  logic                  last_stop_s;

  // Baud counter is held at zero until the frame starts, so START always gets a full bit.
  assign restart_s   = (state_q == ST_IDLE) || (state_q == ST_POP_REQ) || (state_q == ST_POP_WAIT);
  assign last_stop_s = (state_q == ST_STOP) && bit_tick_s && (bit_cnt_q == LAST_STOP);

  rs232_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .bit_tick(bit_tick_s)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          state_d = ST_POP_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP_REQ: begin
        state_d = ST_POP_WAIT;
        wait_d  = WAIT_INIT;
      end
      ST_POP_WAIT: begin
        if (wait_q == 16'd0) begin
          shift_d = fifo.fifo_data;
          par_d   = parity_bit(9'(fifo.fifo_data), PARITY_MODE);
          state_d = ST_START;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = 4'd0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_tick_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
    pop_d   = (state_q == ST_POP_REQ);
    busy_d  = (state_q != ST_IDLE);
    done_d  = last_stop_s;
    bytes_d = last_stop_s ? (bytes_q + 16'd1) : bytes_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= 4'd0;
      wait_q    <= 16'd0;
      tx_q      <= 1'b1;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bytes_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      tx_q      <= tx_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bytes_q   <= bytes_d;
    end
  end

  assign fifo.fifo_pop = pop_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign bytes_sent    = bytes_q;

endmodule

// File: tb/tb_rs232_tx_unloader.sv
// Directed bench: three transmitter instances (8N1, 8E2, 8O2) at four clocks per bit.
module tb_rs232_tx_unloader;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        tx0, tx1, tx2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] bytes0, bytes1, bytes2;
  logic [15:0] pops0;
  int          checks;
  int          errors;

  rs232_tx_unloader_if #(.DATA_WIDTH(8)) f0 ();
  rs232_tx_unloader_if #(.DATA_WIDTH(8)) f1 ();
  rs232_tx_unloader_if #(.DATA_WIDTH(8)) f2 ();

  rs232_tx_unloader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .POP_LATENCY(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(f0),
    .tx(tx0), .busy(busy0), .frame_done(done0), .bytes_sent(bytes0));

  rs232_tx_unloader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(2), .POP_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(f1),
    .tx(tx1), .busy(busy1), .frame_done(done1), .bytes_sent(bytes1));

  rs232_tx_unloader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(2), .POP_LATENCY(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(f2),
    .tx(tx2), .busy(busy2), .frame_done(done2), .bytes_sent(bytes2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pops0 = 16'd0;
  always @(negedge clk) begin
    if (f0.fifo_pop === 1'b1) pops0 <= pops0 + 16'd1;
  end

  function automatic logic get_tx(input int sel);
    case (sel)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_pop(input int sel);
    case (sel)
      0:       return f0.fifo_pop;
      1:       return f1.fifo_pop;
      default: return f2.fifo_pop;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pop(input int sel);
    int n;
    n = 0;
    while (get_pop(sel) !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk1("pop_seen", get_pop(sel), 1'b1);
  endtask

  // exp_bits[i] is the line level of frame bit i (bit 0 = start); drop_en_bit < 0 means no action.
  task automatic check_frame(input int sel, input logic [15:0] exp_bits, input int nbits, input int drop_en_bit);
    int n;
    int tot;
    n = 0;
    while (get_tx(sel) !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("start_seen", get_tx(sel), 1'b0);
    if (get_tx(sel) === 1'b0) begin
      tot = nbits * CPB;
      for (int c = 0; c < tot; c++) begin
        if (c > 0) @(negedge clk);
        if (c == drop_en_bit * CPB + 1) enable = 1'b0;
        chk1("tx_bit", get_tx(sel), exp_bits[c / CPB]);
        chk1("frame_done", get_done(sel), (c == tot - 1));
        chk1("busy_in_frame", get_busy(sel), 1'b1);
      end
      @(negedge clk);
      chk1("tx_after", get_tx(sel), 1'b1);
      chk1("done_after", get_done(sel), 1'b0);
      chk1("busy_after", get_busy(sel), 1'b0);
    end
  endtask

  initial begin
    logic any_bad;
    int   n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    f0.fifo_empty = 1'b0;
    f0.fifo_data  = 8'hA5;
    f1.fifo_empty = 1'b1;
    f1.fifo_data  = 8'h00;
    f2.fifo_empty = 1'b1;
    f2.fifo_data  = 8'h00;

    // Reset held for three cycles with work pending
    repeat (3) begin
      @(negedge clk);
      chk1("rst_tx", tx0, 1'b1);
      chk1("rst_pop", f0.fifo_pop, 1'b0);
      chk1("rst_busy", busy0, 1'b0);
      chk16("rst_bytes", bytes0, 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk1("pop_edge1", f0.fifo_pop, 1'b0);
    @(negedge clk);
    chk1("pop_edge2", f0.fifo_pop, 1'b1);
    f0.fifo_empty = 1'b1;

    // Single byte 0xA5, 8N1
    check_frame(0, 16'b0000_0011_0100_1010, 10, -1);
    chk16("bytes_a5", bytes0, 16'd1);
    chk16("pops_a5", pops0, 16'd1);

    // Empty fifo for 200 cycles
    any_bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (f0.fifo_pop !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) any_bad = 1'b1;
    end
    chk1("empty_idle", any_bad, 1'b0);
    chk16("empty_pops", pops0, 16'd1);

    // Back-to-back 0x01, 0x02, 0x03
    f0.fifo_data  = 8'h01;
    f0.fifo_empty = 1'b0;
    wait_pop(0);
    check_frame(0, 16'b0000_0010_0000_0010, 10, -1);
    f0.fifo_data = 8'h02;
    wait_pop(0);
    check_frame(0, 16'b0000_0010_0000_0100, 10, -1);
    f0.fifo_data = 8'h03;
    wait_pop(0);
    f0.fifo_empty = 1'b1;
    check_frame(0, 16'b0000_0010_0000_0110, 10, -1);
    repeat (30) @(negedge clk);
    chk16("b2b_pops", pops0, 16'd4);
    chk16("b2b_bytes", bytes0, 16'd4);
    chk1("b2b_idle", busy0, 1'b0);

    // Even parity, two stop bits, data 0x07 -> parity 1
    f1.fifo_data  = 8'h07;
    f1.fifo_empty = 1'b0;
    wait_pop(1);
    f1.fifo_empty = 1'b1;
    check_frame(1, 16'b0000_1110_0000_1110, 12, -1);
    chk16("even_bytes", bytes1, 16'd1);

    // Odd parity, two stop bits, data 0x07 -> parity 0
    f2.fifo_data  = 8'h07;
    f2.fifo_empty = 1'b0;
    wait_pop(2);
    f2.fifo_empty = 1'b1;
    check_frame(2, 16'b0000_1100_0000_1110, 12, -1);
    chk16("odd_bytes", bytes2, 16'd1);

    // enable dropped during data bit 3: frame completes, no further pop
    f0.fifo_data  = 8'h55;
    f0.fifo_empty = 1'b0;
    wait_pop(0);
    check_frame(0, 16'b0000_0010_1010_1010, 10, 4);
    repeat (40) @(negedge clk);
    chk16("en_pops", pops0, 16'd5);
    chk16("en_bytes", bytes0, 16'd5);
    chk1("en_idle", busy0, 1'b0);

    // Reset during data bit 3 abandons the frame
    enable = 1'b1;
    wait_pop(0);
    f0.fifo_empty = 1'b1;
    n = 0;
    while (tx0 !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * CPB) @(negedge clk);
    chk1("pre_rst_tx", tx0, 1'b0);
    chk1("pre_rst_busy", busy0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk1("midrst_tx", tx0, 1'b1);
    chk1("midrst_busy", busy0, 1'b0);
    chk16("midrst_bytes", bytes0, 16'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk16("post_rst_bytes", bytes0, 16'd0);
    chk1("post_rst_busy", busy0, 1'b0);
    chk1("post_rst_tx", tx0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
